// File: rtl/mem_port_arbiter.sv
// Two-port (IF/DM) arbiter for a single-ported 16-bit data memory.
// Each access takes LAT busy cycles, then a one-cycle DONE; DM has priority, IF is protected from starvation.
module mem_port_arbiter #(
  parameter int LAT         = 1,
  parameter int STARVE_MAX  = 3,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_done,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_stall,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] LP_CNT0  = 4'(LAT - 1);
  localparam logic [3:0] LP_SMAX  = 4'(STARVE_MAX);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  r_starv;
  logic        r_owner;     // 1 = DM, 0 = IF
  logic        r_wr;
  logic        r_err;
  logic [15:0] r_mem_addr;
  logic [15:0] r_mem_wdata;
  logic [15:0] r_if_rdata;
  logic [15:0] r_dm_rdata;

  logic        w_any;
  logic        w_grant_if;
  logic [15:0] w_sel_addr;
  logic        w_misalign;
  logic        w_last;

  assign w_any      = if_req | dm_req;
  assign w_grant_if = if_req & (~dm_req | (r_starv == LP_SMAX));
  assign w_sel_addr = w_grant_if ? if_addr : dm_addr;
  assign w_misalign = (ALIGN_CHECK != 0) && w_sel_addr[0];
  assign w_last     = (r_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    mem_enable = 1'b0;
    mem_wr     = 1'b0;
    if_done    = 1'b0;
    dm_done    = 1'b0;
    err        = 1'b0;
    case (r_state)
      S_IDLE: if (w_any) w_next = w_misalign ? S_DONE : S_BUSY;
      S_BUSY: begin
        mem_enable = 1'b1;
        // write strobe only on the last busy cycle so each write lands exactly once
        mem_wr     = w_last & r_wr;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if_done = ~r_owner;
        dm_done = r_owner;
        err     = r_err;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= 4'd0;
      r_starv     <= 4'd0;
      r_owner     <= 1'b0;
      r_wr        <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= 16'h0;
      r_mem_wdata <= 16'h0;
      r_if_rdata  <= 16'h0;
      r_dm_rdata  <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_owner <= ~w_grant_if;
          r_wr    <= ~w_grant_if & dm_wr;
          r_err   <= w_misalign;
          r_cnt   <= LP_CNT0;
          // macro pins keep their last values across aborted accesses
          if (!w_misalign) begin
            r_mem_addr <= w_sel_addr;
            if (!w_grant_if) r_mem_wdata <= dm_wdata;
          end
          if (w_grant_if)                    r_starv <= 4'd0;
          else if (if_req && r_starv != LP_SMAX) r_starv <= r_starv + 4'd1;
        end
        S_BUSY: begin
          if (!w_last) r_cnt <= r_cnt - 4'd1;
          else if (!r_wr) begin
            if (r_owner) r_dm_rdata <= mem_data_out;
            else         r_if_rdata <= mem_data_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_wdata;
  assign if_rdata    = r_if_rdata;
  assign dm_rdata    = r_dm_rdata;
  assign if_stall    = if_req & ~if_done;
  assign dm_stall    = dm_req & ~dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: per-port expected responses queued at issue, popped by a done monitor.
// IF reads only the upper half of a 256-word model memory and DM owns the lower half, so expectations are exact at issue time.
module tb_mem_port_arbiter;
  localparam int LAT  = 3;
  localparam int SMAX = 3;

  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0;
  logic [15:0] if_addr = 16'h0, dm_addr = 16'h0, dm_wdata = 16'h0;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_data_in, mem_data_out;
  logic        if_done, if_stall, dm_done, dm_stall, mem_enable, mem_wr, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LAT(LAT), .STARVE_MAX(SMAX), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .err(err)
  );

  logic [15:0] phys [0:255];
  logic [15:0] refm [0:255];
  assign mem_data_out = phys[mem_addr[7:0]];
  always @(posedge clk) if (mem_wr) phys[mem_addr[7:0]] <= mem_data_in;

  typedef struct packed { logic err; logic [15:0] rdata; } exp_t;
  exp_t dm_q[$], if_q[$];
  exp_t mon_e;
  logic [15:0] dm_last = 16'h0, if_last = 16'h0;
  int n_chk = 0, n_pass = 0, m_chk = 0, m_pass = 0;
  int cyc = 0, en_cnt = 0, wr_cnt = 0, dm_done_cyc = 0, if_done_cyc = 0;
  int glog[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    m_chk++;
    if (act === exp) m_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) if (rst) begin
    if (mem_enable) en_cnt++;
    if (mem_wr) wr_cnt++;
    if (dm_done) begin
      dm_done_cyc = cyc;
      glog.push_back(1);
      if (dm_q.size() == 0) begin m_chk++; $display("FAIL dm_done_unexpected: got 1 expected 0 (cycle %0d)", cyc); end
      else begin
        mon_e = dm_q.pop_front();
        mchk("dm_rdata", {16'h0, dm_rdata}, {16'h0, mon_e.rdata});
        mchk("dm_err", {31'h0, err}, {31'h0, mon_e.err});
      end
    end
    if (if_done) begin
      if_done_cyc = cyc;
      glog.push_back(0);
      if (if_q.size() == 0) begin m_chk++; $display("FAIL if_done_unexpected: got 1 expected 0 (cycle %0d)", cyc); end
      else begin
        mon_e = if_q.pop_front();
        mchk("if_rdata", {16'h0, if_rdata}, {16'h0, mon_e.rdata});
        mchk("if_err", {31'h0, err}, {31'h0, mon_e.err});
      end
    end
    if (err && !dm_done && !if_done) begin m_chk++; $display("FAIL stray_err: got 1 expected 0 (cycle %0d)", cyc); end
  end

  function automatic logic [15:0] dm_rand_addr(input bit allow_odd);
    logic [15:0] a;
    a = 16'($urandom_range(0, 63) * 2);
    if (allow_odd && $urandom_range(0, 7) == 0) a[0] = 1'b1;
    return a;
  endfunction

  function automatic logic [15:0] if_rand_addr(input bit allow_odd);
    logic [15:0] a;
    a = 16'(128 + $urandom_range(0, 63) * 2);
    if (allow_odd && $urandom_range(0, 7) == 0) a[0] = 1'b1;
    return a;
  endfunction

  // called just after a rising edge; returns cycles from request to done (cycle 0 = request cycle)
  task automatic dm_op(input logic wr, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output bit stall_ok);
    exp_t e;
    e.err = a[0];
    e.rdata = dm_last;
    if (!a[0]) begin
      if (wr) refm[a[7:0]] = d;
      else begin e.rdata = refm[a[7:0]]; dm_last = e.rdata; end
    end
    dm_q.push_back(e);
    dm_req = 1'b1; dm_wr = wr; dm_addr = a; dm_wdata = d;
    lat = -1; stall_ok = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dm_done) begin lat = n; break; end
      if (!dm_stall) stall_ok = 1'b0;
    end
    if (lat < 0) begin n_chk++; $display("FAIL dm_timeout: got no dm_done expected done within 200 cycles"); end
    @(posedge clk); #1;
    dm_req = 1'b0; dm_wr = 1'b0;
  endtask

  task automatic if_op(input logic [15:0] a, output int lat, output bit stall_ok);
    exp_t e;
    e.err = a[0];
    e.rdata = if_last;
    if (!a[0]) begin e.rdata = refm[a[7:0]]; if_last = e.rdata; end
    if_q.push_back(e);
    if_req = 1'b1; if_addr = a;
    lat = -1; stall_ok = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (if_done) begin lat = n; break; end
      if (!if_stall) stall_ok = 1'b0;
    end
    if (lat < 0) begin n_chk++; $display("FAIL if_timeout: got no if_done expected done within 200 cycles"); end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, e0, w0, g0, bad;
    bit sok;
    for (int i = 0; i < 256; i++) begin
      phys[i] = 16'($urandom);
      refm[i] = phys[i];
    end
    phys[16] = 16'hBEEF; refm[16] = 16'hBEEF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {25'h0, if_done, dm_done, err, mem_enable, mem_wr, if_stall, dm_stall}, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_mem_data_in", {16'h0, mem_data_in}, 32'h0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // DM read latency / enable window / stall
    e0 = en_cnt;
    dm_op(1'b0, 16'h0010, 16'h0, lat, sok);
    chk("dm_read_latency", lat, LAT + 1);
    chk("dm_read_enable_cycles", en_cnt - e0, LAT);
    chk("dm_read_stall", {31'h0, sok}, 32'h1);

    // write then read back
    w0 = wr_cnt;
    dm_op(1'b1, 16'h0020, 16'h1234, lat, sok);
    chk("dm_write_strobes", wr_cnt - w0, 1);
    dm_op(1'b0, 16'h0020, 16'h0, lat, sok);
    chk("if_rdata_untouched", {16'h0, if_rdata}, {16'h0, if_last});

    // misaligned abort
    e0 = en_cnt;
    dm_op(1'b0, 16'h0011, 16'h0, lat, sok);
    chk("misalign_latency", lat, 1);
    chk("misalign_no_enable", en_cnt - e0, 0);

    // fresh reset so the starvation counter starts at 0
    rst = 1'b0; dm_last = 16'h0; if_last = 16'h0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // both requesting continuously: DM x3 then IF
    g0 = glog.size();
    fork
      begin : dm_stream
        int l; bit s;
        for (int k = 0; k < 6; k++) dm_op(1'b0, dm_rand_addr(1'b0), 16'h0, l, s);
      end
      begin : if_stream
        int l; bit s;
        for (int k = 0; k < 2; k++) if_op(if_rand_addr(1'b0), l, s);
      end
    join
    chk("arb_grant_count", glog.size() - g0, 8);
    for (int k = 0; k < 8; k++) begin
      int exp_dm;
      exp_dm = ((k % 4) == 3) ? 0 : 1;
      if (g0 + k < glog.size()) chk($sformatf("arb_grant_%0d", k), glog[g0 + k], exp_dm);
    end

    // simultaneous request with starvation count 0
    fork
      begin : dm_one
        int l; bit s;
        dm_op(1'b0, dm_rand_addr(1'b0), 16'h0, l, s);
      end
      begin : if_one
        int l; bit s;
        if_op(if_rand_addr(1'b0), l, s);
        chk("same_cycle_if_stall", {31'h0, s}, 32'h1);
      end
    join
    chk("same_cycle_gap", if_done_cyc - dm_done_cyc, LAT + 2);

    // reset in the middle of a write, before its strobe
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0040; dm_wdata = ~refm[8'h40];
    @(negedge clk);
    @(negedge clk);
    chk("midrst_busy", {31'h0, mem_enable}, 32'h1);
    rst = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    #1;
    chk("midrst_outputs", {25'h0, if_done, dm_done, err, mem_enable, mem_wr, if_stall, dm_stall}, 32'h0);
    chk("midrst_rdata", {if_rdata, dm_rdata}, 32'h0);
    dm_last = 16'h0; if_last = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    chk("midrst_write_lost", {16'h0, phys[8'h40]}, {16'h0, refm[8'h40]});
    @(posedge clk); #1;
    dm_op(1'b0, 16'h0040, 16'h0, lat, sok);
    chk("post_rst_latency", lat, LAT + 1);

    // randomized concurrent traffic
    fork
      begin : dm_rand
        int l; bit s;
        for (int k = 0; k < 40; k++) begin
          dm_op(1'($urandom_range(0, 1)), dm_rand_addr(1'b1), 16'($urandom), l, s);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
      begin : if_rand
        int l; bit s;
        for (int k = 0; k < 40; k++) begin
          if_op(if_rand_addr(1'b1), l, s);
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
      end
    join

    repeat (3) @(posedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (phys[i] !== refm[i]) bad++;
    chk("final_memory_mismatches", bad, 0);
    chk("queues_drained", dm_q.size() + if_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass + m_pass, n_chk + m_chk);
    $finish;
  end
endmodule
